muldiv_unit: RTL

Iterative multiply/divide unit with HI/LO result registers. Sits beside the combinational ALU in the EX stage and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO, which the single-cycle ALU cannot. The pipeline stalls while `busy` is high and reads results from `hi`/`lo`. Operand width is parametrised. A synchronous flush aborts an in-flight operation on an exception.

---
 rtl/muldiv_unit_if.sv | 18 +
 rtl/muldiv_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle between the EX stage and the multiply/divide unit
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, dz, hi, lo);
  modport slave (input start, op, a, b, flush, output busy, done, dz, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider with HI/LO result registers
module muldiv_unit #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             st;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               busy;
  logic               done;
  logic               dz;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               sgn;
  logic               dzero;
  logic [WIDTH:0]     ax;
  logic [WIDTH:0]     bx;
  logic [WIDTH:0]     am;
  logic [WIDTH:0]     bm;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     tr;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // Operands are sign-extended by one bit so the most-negative value has a representable magnitude
  assign sgn   = !bus.op[0];
  assign ax    = {sgn & bus.a[WIDTH-1], bus.a};
  assign bx    = {sgn & bus.b[WIDTH-1], bus.b};
  assign am    = ax[WIDTH] ? -ax : ax;
  assign bm    = bx[WIDTH] ? -bx : bx;
  assign dzero = bus.op[1] && bus.b == '0;

  // p holds {accumulator, multiplier} for MULT and {remainder, dividend/quotient} for DIV
  assign sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, m};
  assign tr   = p[2*WIDTH-1:WIDTH-1];
  assign diff = tr - {1'b0, m};
  assign prod = neg_q ? -p : p;
  assign quo  = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
  assign rem  = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.dz   = dz;
  assign bus.hi   = hi;
  assign bus.lo   = lo;

  // Control FSM and datapath: accept in IDLE, WIDTH iterations in RUN, sign fix-up and write-back in FIX
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st     <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dz     <= 1'b0;
      p      <= '0;
      m      <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (bus.flush) begin
      st   <= IDLE;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (bus.start) begin
          if (bus.op == 3'b100) begin
            hi   <= bus.a;
            done <= 1'b1;
          end else if (bus.op == 3'b101) begin
            lo   <= bus.a;
            done <= 1'b1;
          end else if (!bus.op[2] && dzero) begin
            hi   <= bus.a;
            lo   <= '1;
            dz   <= 1'b1;
            done <= 1'b1;
          end else if (!bus.op[2]) begin
            st     <= RUN;
            busy   <= 1'b1;
            cnt    <= '0;
            dz     <= 1'b0;
            is_div <= bus.op[1];
            neg_q  <= ax[WIDTH] ^ bx[WIDTH];
            neg_r  <= ax[WIDTH];
            p      <= {{WIDTH{1'b0}}, bus.op[1] ? am[WIDTH-1:0] : bm[WIDTH-1:0]};
            m      <= bus.op[1] ? bm[WIDTH-1:0] : am[WIDTH-1:0];
          end
        end
        RUN: begin
          p   <= is_div ? (diff[WIDTH] ? {tr[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                                       : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1})
                        : (p[0] ? {sum, p[WIDTH-1:1]} : {1'b0, p[2*WIDTH-1:1]});
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) st <= FIX;
        end
        FIX: begin
          hi   <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
          lo   <= is_div ? quo : prod[WIDTH-1:0];
          done <= 1'b1;
          busy <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
